apb4_master: RTL and testbench

- APB4 initiator (requester) that drives slave peripherals such as the timer, UART and GPIO blocks.
- Converts a simple valid/ready request/response channel from a CPU-side or DMA-side agent into APB4 SETUP/ACCESS transfers.
- Returns read data and error status on the response channel.
- Contains a programmable-length watchdog so that a hung slave (pready never asserted) cannot stall the bus.

---
 rtl/apb4_master_pkg.sv | 15 +
 rtl/apb4_master_wdt.sv | 23 ++
 rtl/apb4_master.sv | 114 +++++++++++
 tb/tb_apb4_master.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/apb4_master_pkg.sv
// apb4_master_pkg: FSM state encoding and pprot bit constants for the APB4 initiator
package apb4_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb4_mst_state_e;

    localparam logic [2:0] PPROT_PRIV  = 3'b001;
    localparam logic [2:0] PPROT_NSEC  = 3'b010;
    localparam logic [2:0] PPROT_INSTR = 3'b100;

endpackage

// File: rtl/apb4_master_wdt.sv
// apb4_master_wdt: saturating wait-state counter that flags expiry on the TIMEOUT-th stalled cycle
module apb4_master_wdt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] MAX  = {CW{1'b1}};

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;

    // expiry fires in the cycle whose increment would make the count reach TIMEOUT
    assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);
endmodule

// File: rtl/apb4_master.sv
// apb4_master: valid/ready request channel to APB4 SETUP/ACCESS transfers with watchdog abort
module apb4_master
    import apb4_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_tmo_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i
);
    apb4_mst_state_e         state_q;
    logic                    req_ready_q, rsp_valid_q, rsp_err_q, rsp_tmo_q;
    logic                    psel_q, penable_q, pwrite_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, pwdata_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [2:0]              pprot_q;
    logic [DATA_WIDTH/8-1:0] pstrb_q;
    logic                    expire;

    apb4_master_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_q == SETUP),
        .en_i     (state_q == ACCESS && !pready_i),
        .expire_o (expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            paddr_q     <= '0;
            pprot_q     <= '0;
            pstrb_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    paddr_q     <= req_addr_i;
                    pwrite_q    <= req_write_i;
                    pwdata_q    <= req_wdata_i;
                    pstrb_q     <= req_write_i ? req_strb_i : '0;
                    pprot_q     <= req_prot_i;
                    psel_q      <= 1'b1;
                    req_ready_q <= 1'b0;
                    state_q     <= SETUP;
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: if (pready_i || expire) begin
                    // pready has priority over a watchdog expiry in the same cycle
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= (pready_i && !pwrite_q) ? prdata_i : '0;
                    rsp_err_q   <= pready_i ? pslverr_i : 1'b1;
                    rsp_tmo_q   <= !pready_i;
                    state_q     <= RESP;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tmo_o   = rsp_tmo_q;
    assign paddr_o     = paddr_q;
    assign pprot_o     = pprot_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;
endmodule

// File: tb/tb_apb4_master.sv
// tb_apb4_master: directed and randomized APB4 transfers checked against a transfer-level reference model
module tb_apb4_master;
    import apb4_master_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic        rsp_err, rsp_tmo, psel, penable, pwrite, pready, pslverr;
    logic [31:0] req_addr, req_wdata, rsp_rdata, paddr, pwdata, prdata;
    logic [3:0]  req_strb, pstrb;
    logic [2:0]  req_prot, pprot;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    apb4_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .req_prot_i(req_prot),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo),
        .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
        .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
        .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr);
        chk("paddr", paddr, a);
        chk("pwrite", pwrite, w);
        chk("pwdata", pwdata, wd);
        chk("pstrb", pstrb, st);
        chk("pprot", pprot, pr);
    endtask

    task automatic chk_rsp(input logic v, input logic [31:0] rd, input logic e, input logic t);
        chk("rsp_valid", rsp_valid, v);
        chk("rsp_rdata", rsp_rdata, rd);
        chk("rsp_err", rsp_err, e);
        chk("rsp_tmo", rsp_tmo, t);
    endtask

    // One whole transfer; the slave answers after `waits` stalled ACCESS cycles.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int waits,
                        input logic [31:0] rd, input logic se, input int hold);
        logic        tmo_e;
        int          nacc;
        logic [3:0]  st_e;
        logic [31:0] rd_e;
        logic        err_e;
        tmo_e = (TMO != 0) && (waits >= TMO);
        nacc  = tmo_e ? TMO : waits + 1;
        st_e  = w ? st : 4'h0;
        rd_e  = (tmo_e || w) ? 32'h0 : rd;
        err_e = tmo_e ? 1'b1 : se;
        chk("idle_req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd;
        req_strb = st; req_prot = pr;
        @(negedge clk);
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; req_strb = ~st; req_prot = ~pr;
        chk("setup_psel", psel, 1'b1);
        chk("setup_penable", penable, 1'b0);
        chk("setup_req_ready", req_ready, 1'b0);
        chk_bus(a, w, wd, st_e, pr);
        for (int k = 1; k <= nacc; k++) begin
            @(negedge clk);
            chk("access_psel", psel, 1'b1);
            chk("access_penable", penable, 1'b1);
            chk("access_rsp_valid", rsp_valid, 1'b0);
            chk_bus(a, w, wd, st_e, pr);
            pready  = !tmo_e && (k == nacc);
            prdata  = pready ? rd : ~rd;
            pslverr = pready ? se : ~se;
        end
        @(negedge clk);
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        chk("resp_psel", psel, 1'b0);
        chk("resp_penable", penable, 1'b0);
        chk("resp_req_ready", req_ready, 1'b0);
        chk_rsp(1'b1, rd_e, err_e, tmo_e);
        repeat (hold) begin
            @(negedge clk);
            chk_rsp(1'b1, rd_e, err_e, tmo_e);
            chk_bus(a, w, wd, st_e, pr);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk_rsp(1'b0, rd_e, err_e, tmo_e);
        chk("done_psel", psel, 1'b0);
        chk_bus(a, w, wd, st_e, pr);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        req_strb = '0; req_prot = '0; rsp_ready = 1'b0; pready = 1'b0; prdata = '0;
        pslverr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk_rsp(1'b0, 32'h0, 1'b0, 1'b0);
        chk_bus(32'h0, 1'b0, 32'h0, 4'h0, 3'h0);

        xfer(32'h0C, 1'b1, 32'hDEADBEEF, 4'hF, PPROT_PRIV, 0, 32'hCAFEF00D, 1'b0, 0);
        xfer(32'h08, 1'b0, 32'h55AA55AA, 4'hF, PPROT_NSEC, 3, 32'h12345678, 1'b0, 1);
        xfer(32'h10, 1'b0, 32'h0, 4'h3, PPROT_INSTR, 1, 32'hA5A5A5A5, 1'b1, 5);
        xfer(32'h20, 1'b0, 32'h0, 4'h0, 3'h0, 10, 32'h11112222, 1'b0, 0);
        xfer(32'h24, 1'b0, 32'h0, 4'h0, 3'h0, TMO - 1, 32'h33334444, 1'b0, 0);
        xfer(32'h28, 1'b1, 32'h01020304, 4'h5, 3'h7, TMO, 32'h0, 1'b0, 2);

        // reset in the middle of ACCESS
        req_valid = 1'b1; req_addr = 32'h40; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_penable", penable, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_psel", psel, 1'b0);
        chk("midrst_penable", penable, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b1);
        xfer(32'h44, 1'b0, 32'h0, 4'hF, 3'h2, 2, 32'h87654321, 1'b0, 0);

        for (int i = 0; i < 40; i++)
            xfer($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                 3'($urandom), $urandom_range(0, 6), $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
